// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; grant costs one bubble, beats pass combinationally.
// Backpressure: o_full stalls the granted requester in place; optional FIFO_ARB_ALM_GATE_EN holds new grants off on o_alm_full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 128,
  parameter int BURST_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         i_wren,
  output logic [DATA_W-1:0]            i_wrdata,
  input  logic                         o_full,
  input  logic                         o_alm_full,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;

  logic            pick_vld;
  logic [IDW-1:0]  pick_idx;
  logic            arb_ok;
  logic            accept;

`ifdef FIFO_ARB_ALM_GATE_EN
  assign arb_ok = !o_alm_full;
`else
  logic unused_alm_full;
  assign unused_alm_full = o_alm_full;
  assign arb_ok = 1'b1;
`endif

  // Scan from farthest to nearest so the nearest valid index after rr_ptr wins.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_w;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    idx_w    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx   = (int'(rr_ptr_q) + i) % NUM_REQ;
      idx_w = idx[IDW-1:0];
      if (req_valid[idx_w]) begin
        pick_vld = 1'b1;
        pick_idx = idx_w;
      end
    end
  end

  assign accept = (state_q == GRANT) && req_valid[grant_q] && !o_full;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= IDW'(NUM_REQ - 1);
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld && arb_ok) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          if (req_last[grant_q] || beat_cnt_q == CNTW'(BURST_MAX - 1)) begin
            rr_ptr_d = grant_q;
            state_d  = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNTW'(1);
          end
        end else if (!req_valid[grant_q]) begin
          // Requester walked away mid-grant: release so nobody deadlocks.
          rr_ptr_d = grant_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    i_wren    = accept;
    i_wrdata  = '0;
    if (state_q == GRANT) begin
      req_ready[grant_q] = !o_full && req_valid[grant_q];
    end
    if (accept) begin
      i_wrdata = req_data[int'(grant_q)*DATA_W +: DATA_W];
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: requester model plus expected-beat queue checked at every negedge.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 128;
  localparam int BURST_MAX = 4;

  logic                      clk = 1'b0;
  logic                      rstn = 1'b0;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      i_wren;
  logic [DATA_W-1:0]         i_wrdata;
  logic                      o_full;
  logic                      o_alm_full;
  logic [1:0]                grant_id;
  logic                      busy;

  typedef struct packed {
    logic [1:0]        id;
    logic [DATA_W-1:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   rem[NUM_REQ];
  bit   use_last[NUM_REQ];
  int   seq[NUM_REQ];
  int   errors = 0;
  int   checks = 0;
  int   cyc, wr_count, first_wr, last_wr;
  logic [NUM_REQ-1:0] hs;

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .i_wren(i_wren), .i_wrdata(i_wrdata), .o_full(o_full), .o_alm_full(o_alm_full),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mk(int id, int s);
    logic [DATA_W-1:0] d;
    d = {32'hC0DE0000 + 32'(id), 32'h0, 32'(s) * 32'h01010101, 32'(s)};
    return d;
  endfunction

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = rem[i] > 0;
      req_last[i]  = use_last[i] && rem[i] == 1;
      req_data[i*DATA_W +: DATA_W] = mk(i, seq[i]);
    end
  endtask

  task automatic push_exp(int id, int s);
    exp_t e;
    e.id  = 2'(id);
    e.dat = mk(id, s);
    exp_q.push_back(e);
  endtask

  // Negedge monitor: every write is matched against the head of the expected queue.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    cyc++;
    hs = req_valid & req_ready;
    checks++;
    if ($countones(req_ready) > 1) begin
      errors++;
      $display("FAIL ready_onehot: got %b want one-hot or zero", req_ready);
    end
    if (i_wren) begin
      checks++;
      if (o_full) begin
        errors++;
        $display("FAIL write_while_full: got i_wren=1 with o_full=1 want i_wren=0");
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got id=%0d data=%h want no write", grant_id, i_wrdata);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (i_wrdata !== e.dat || grant_id !== e.id) begin
          errors++;
          $display("FAIL beat: got id=%0d data=%h want id=%0d data=%h", grant_id, i_wrdata, e.id, e.dat);
        end
      end
      wr_count++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
    end else begin
      checks++;
      if (i_wrdata !== '0) begin
        errors++;
        $display("FAIL idle_data: got %h want 0", i_wrdata);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs[i]) begin
        rem[i]--;
        seq[i]++;
      end
    end
    hs = '0;
    drive();
  endtask

  task automatic run_until_empty(int budget, string name);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      sample();
      advance();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d beats outstanding want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_until_wr(int target, int budget, string name);
    int n = 0;
    while (wr_count < target && n < budget) begin
      sample();
      advance();
      n++;
    end
    checks++;
    if (wr_count < target) begin
      errors++;
      $display("FAIL %s_timeout: got %0d writes want %0d", name, wr_count, target);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_REQ; i++) begin
      rem[i] = 0; seq[i] = 0; use_last[i] = 1'b0;
    end
    hs = '0;
    drive();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    o_full = 1'b0;
    o_alm_full = 1'b0;
    clear_model();
    #12;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0; wr_count = 0; first_wr = -1; last_wr = -1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    o_full = 1'b0;
    o_alm_full = 1'b0;
    clear_model();
    for (int i = 0; i < NUM_REQ; i++) rem[i] = 1;
    drive();
    #7;
    checks++;
    if (req_ready !== '0 || i_wren !== 1'b0 || i_wrdata !== '0 || busy !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: got ready=%b wren=%b data=%h busy=%b gid=%0d want all 0",
               req_ready, i_wren, i_wrdata, busy, grant_id);
    end
    do_reset();
  endtask

  task automatic test_single_burst();
    do_reset();
    rem[0] = 3; use_last[0] = 1'b1;
    for (int k = 0; k < 3; k++) push_exp(0, k);
    drive();
    run_until_empty(20, "single");
    checks++;
    if (first_wr != 2 || last_wr != 4 || wr_count != 3) begin
      errors++;
      $display("FAIL single_timing: got first=%0d last=%0d n=%0d want 2 4 3", first_wr, last_wr, wr_count);
    end
    sample();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got busy=%b want 0", busy);
    end
    advance();
  endtask

  task automatic test_rotation();
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) rem[i] = 1000;
    for (int g = 0; g < 5; g++)
      for (int k = 0; k < BURST_MAX; k++) push_exp(g % NUM_REQ, (g / NUM_REQ) * BURST_MAX + k);
    drive();
    run_until_empty(100, "rotation");
    for (int i = 0; i < NUM_REQ; i++) rem[i] = 0;
    drive();
    checks++;
    if (cyc != 25) begin
      errors++;
      $display("FAIL rotation_cycles: got %0d want 25", cyc);
    end
    sample();
    advance();
    sample();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rotation_idle: got busy=%b want 0", busy);
    end
    advance();
  endtask

  task automatic test_full_stall();
    do_reset();
    rem[2] = 4; use_last[2] = 1'b1;
    for (int k = 0; k < 4; k++) push_exp(2, k);
    drive();
    run_until_wr(2, 20, "full_pre");
    o_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sample();
      checks++;
      if (req_ready !== '0 || i_wren !== 1'b0 || grant_id !== 2'd2 || busy !== 1'b1) begin
        errors++;
        $display("FAIL full_stall: got ready=%b wren=%b gid=%0d busy=%b want 0 0 2 1",
                 req_ready, i_wren, grant_id, busy);
      end
      advance();
    end
    o_full = 1'b0;
    run_until_empty(20, "full_post");
    checks++;
    if (wr_count != 4) begin
      errors++;
      $display("FAIL full_total: got %0d beats want 4", wr_count);
    end
  endtask

  task automatic test_drop();
    do_reset();
    rem[0] = 1; use_last[0] = 1'b0;
    for (int i = 1; i < NUM_REQ; i++) begin
      rem[i] = 1; use_last[i] = 1'b1;
    end
    for (int i = 0; i < NUM_REQ; i++) push_exp(i, 0);
    drive();
    run_until_empty(40, "drop");
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    rem[0] = 4; use_last[0] = 1'b1;
    for (int k = 0; k < 4; k++) push_exp(0, k);
    drive();
    run_until_wr(1, 20, "midrst_pre");
    #2;
    checks++;
    if (i_wren !== 1'b1) begin
      errors++;
      $display("FAIL midrst_beat2: got i_wren=%b want 1", i_wren);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (i_wren !== 1'b0 || req_ready !== '0 || busy !== 1'b0 || grant_id !== 2'd0 || i_wrdata !== '0) begin
      errors++;
      $display("FAIL midrst_async: got wren=%b ready=%b busy=%b gid=%0d want all 0",
               i_wren, req_ready, busy, grant_id);
    end
    exp_q.delete();
    hs = '0;
    rem[3] = 1; use_last[3] = 1'b1;
    drive();
    for (int k = seq[0]; k < 4; k++) push_exp(0, k);
    push_exp(3, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    run_until_empty(30, "midrst_post");
  endtask

  task automatic test_alm_gate();
    do_reset();
    o_alm_full = 1'b1;
    rem[1] = 1; use_last[1] = 1'b1;
    push_exp(1, 0);
    drive();
`ifdef FIFO_ARB_ALM_GATE_EN
    for (int c = 0; c < 4; c++) begin
      sample();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL alm_gated: got busy=%b want 0", busy);
      end
      advance();
    end
    o_alm_full = 1'b0;
    sample();
    advance();
    sample();
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL alm_release: got busy=%b gid=%0d want 1 1", busy, grant_id);
    end
    advance();
`else
    sample();
    advance();
    sample();
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL alm_ignored: got busy=%b gid=%0d want 1 1", busy, grant_id);
    end
    advance();
`endif
    run_until_empty(10, "alm");
    o_alm_full = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_rotation();
    test_full_stall();
    test_drop();
    test_reset_mid_burst();
    test_alm_gate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
